// File: rtl/bp_me_mem_cmd_arbiter.sv
// Two-requester arbiter onto one cce_mem port: registered command issue, credit-bounded
// in-flight count, in-order response steering by requester tag. Define BP_MEM_ARB_FIXED_PRIO_EN for fixed priority.
module bp_me_mem_cmd_arbiter #(
  parameter int unsigned msg_width_p       = 256,
  parameter int unsigned max_outstanding_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,

  input  logic [msg_width_p-1:0] req0_cmd_i,
  input  logic                   req0_cmd_v_i,
  output logic                   req0_cmd_ready_o,
  output logic [msg_width_p-1:0] req0_resp_o,
  output logic                   req0_resp_v_o,
  input  logic                   req0_resp_yumi_i,

  input  logic [msg_width_p-1:0] req1_cmd_i,
  input  logic                   req1_cmd_v_i,
  output logic                   req1_cmd_ready_o,
  output logic [msg_width_p-1:0] req1_resp_o,
  output logic                   req1_resp_v_o,
  input  logic                   req1_resp_yumi_i,

  output logic [msg_width_p-1:0] mem_cmd_o,
  output logic                   mem_cmd_v_o,
  input  logic                   mem_cmd_ready_i,
  input  logic [msg_width_p-1:0] mem_resp_i,
  input  logic                   mem_resp_v_i,
  output logic                   mem_resp_yumi_o,

  output logic                   error_o
);

  localparam int unsigned cnt_w_lp = $clog2(max_outstanding_p + 1);
  localparam int unsigned ptr_w_lp = $clog2(max_outstanding_p);

  logic [msg_width_p-1:0]       data_q, data_d;
  logic                         full_q, full_d;
  logic [cnt_w_lp-1:0]          cnt_q, cnt_d;
  logic [ptr_w_lp-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [max_outstanding_p-1:0] tag_q, tag_d;
  logic                         error_q, error_d;

  logic fifo_empty, head_id, resp_v, yumi, credit_ok, load_en;
  logic grant0, grant1, accept;

  // Tag FIFO occupancy always equals the credit count, so cnt_q doubles as its level.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    head_id    = tag_q[rd_q];
    resp_v     = reset_n_i & mem_resp_v_i & ~fifo_empty;
    yumi       = resp_v & (head_id ? req1_resp_yumi_i : req0_resp_yumi_i);
    credit_ok  = (cnt_q != cnt_w_lp'(max_outstanding_p)) | yumi;
    load_en    = reset_n_i & (~full_q | mem_cmd_ready_i) & credit_ok;
  end

`ifdef BP_MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = req0_cmd_v_i;
    grant1 = ~req0_cmd_v_i & req1_cmd_v_i;
  end
`else
  logic rr_q, rr_d;

  // rr_q=1 favours req1; after any grant the pointer moves to the other side.
  always_comb begin
    grant0 = req0_cmd_v_i & (~req1_cmd_v_i | ~rr_q);
    grant1 = req1_cmd_v_i & (~req0_cmd_v_i |  rr_q);
    rr_d   = (load_en & (grant0 | grant1)) ? grant0 : rr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) rr_q <= 1'b0;
    else            rr_q <= rr_d;
  end
`endif

  always_comb begin
    accept  = load_en & (grant0 | grant1);
    full_d  = accept | (full_q & ~mem_cmd_ready_i);
    data_d  = accept ? (grant1 ? req1_cmd_i : req0_cmd_i) : data_q;
    tag_d   = tag_q;
    if (accept) tag_d[wr_q] = grant1;
    wr_d    = accept ? wr_q + ptr_w_lp'(1) : wr_q;
    rd_d    = yumi   ? rd_q + ptr_w_lp'(1) : rd_q;
    cnt_d   = cnt_q;
    if (accept & ~yumi) cnt_d = cnt_q + cnt_w_lp'(1);
    if (~accept & yumi) cnt_d = cnt_q - cnt_w_lp'(1);
    error_d = error_q | (mem_resp_v_i & fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      data_q  <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      tag_q   <= '0;
      error_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    req0_cmd_ready_o = load_en & grant0;
    req1_cmd_ready_o = load_en & grant1;
    mem_cmd_o        = data_q;
    mem_cmd_v_o      = reset_n_i & full_q;
    req0_resp_o      = mem_resp_i;
    req1_resp_o      = mem_resp_i;
    req0_resp_v_o    = resp_v & ~head_id;
    req1_resp_v_o    = resp_v &  head_id;
    mem_resp_yumi_o  = yumi;
    error_o          = reset_n_i & error_q;
  end

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Directed self-checking bench for bp_me_mem_cmd_arbiter (default build, max_outstanding_p=8).
module tb_bp_me_mem_cmd_arbiter;

  localparam int unsigned W = 256;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] req0_cmd, req1_cmd, req0_resp, req1_resp, mem_cmd, mem_resp;
  logic         req0_v, req0_ready, req0_resp_v, req0_yumi;
  logic         req1_v, req1_ready, req1_resp_v, req1_yumi;
  logic         mem_cmd_v, mem_ready, mem_resp_v, mem_yumi, error;

  int checks = 0;
  int errors = 0;
  int mem_hs = 0;

  always #5 clk = ~clk;

  bp_me_mem_cmd_arbiter #(.msg_width_p(W), .max_outstanding_p(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req0_cmd_i(req0_cmd), .req0_cmd_v_i(req0_v), .req0_cmd_ready_o(req0_ready),
    .req0_resp_o(req0_resp), .req0_resp_v_o(req0_resp_v), .req0_resp_yumi_i(req0_yumi),
    .req1_cmd_i(req1_cmd), .req1_cmd_v_i(req1_v), .req1_cmd_ready_o(req1_ready),
    .req1_resp_o(req1_resp), .req1_resp_v_o(req1_resp_v), .req1_resp_yumi_i(req1_yumi),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_ready),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_yumi),
    .error_o(error)
  );

  // Memory-side handshakes, sampled mid-cycle when inputs are stable.
  always @(negedge clk)
    if (reset_n && mem_cmd_v && mem_ready) mem_hs++;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ord [6];
  int s0, s1, g, acc, hs0;

  initial begin
    reset_n = 1'b0;
    req0_cmd = '0; req1_cmd = '0; mem_resp = '0;
    req0_v = 1'b1; req1_v = 1'b1; req0_yumi = 1'b1; req1_yumi = 1'b1;
    mem_ready = 1'b1; mem_resp_v = 1'b1;

    // 1: reset with every valid asserted
    repeat (3) tick();
    chk("rst_req0_ready", W'(req0_ready), W'(0));
    chk("rst_req1_ready", W'(req1_ready), W'(0));
    chk("rst_mem_cmd_v", W'(mem_cmd_v), W'(0));
    chk("rst_resp_v", W'({req0_resp_v, req1_resp_v}), W'(0));
    chk("rst_mem_yumi", W'(mem_yumi), W'(0));
    chk("rst_error", W'(error), W'(0));

    req0_v = 1'b0; req1_v = 1'b0; req0_yumi = 1'b0; req1_yumi = 1'b0; mem_resp_v = 1'b0;
    reset_n = 1'b1;
    tick();

    // 2: single req0 command and its response
    req0_cmd = W'(32'hA5); req0_v = 1'b1;
    #1 chk("t2_ready0", W'(req0_ready), W'(1));
    tick();
    req0_v = 1'b0;
    #1;
    chk("t2_mem_v", W'(mem_cmd_v), W'(1));
    chk("t2_mem_data", mem_cmd, W'(32'hA5));
    tick();
    mem_resp = W'(32'h5A); mem_resp_v = 1'b1;
    #1;
    chk("t2_resp0_v", W'(req0_resp_v), W'(1));
    chk("t2_resp1_v", W'(req1_resp_v), W'(0));
    chk("t2_resp0_data", req0_resp, W'(32'h5A));
    req0_yumi = 1'b1;
    #1 chk("t2_mem_yumi", W'(mem_yumi), W'(1));
    tick();
    mem_resp_v = 1'b0; req0_yumi = 1'b0;
    #1 chk("t2_error", W'(error), W'(0));

    // 3: both stream 3 commands each; req0 was granted last so req1 leads
    s0 = 0; s1 = 0;
    for (int i = 0; i < 6; i++) begin
      req0_v = (s0 < 3); req1_v = (s1 < 3);
      req0_cmd = W'(32'h100 + s0); req1_cmd = W'(32'h200 + s1);
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
      g = (s0 < 3) ? 0 : 1;
`else
      g = (i % 2 == 0) ? 1 : 0;
`endif
      #1;
      chk("t3_ready0", W'(req0_ready), W'(g == 0));
      chk("t3_ready1", W'(req1_ready), W'(g == 1));
      ord[i] = g;
      tick();
      chk("t3_mem_data", mem_cmd, (g == 0) ? W'(32'h100 + s0) : W'(32'h200 + s1));
      if (g == 0) s0++; else s1++;
    end
    req0_v = 1'b0; req1_v = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      mem_resp = W'(32'h300 + k); mem_resp_v = 1'b1;
      #1;
      chk("t3_resp0_v", W'(req0_resp_v), W'(ord[k] == 0));
      chk("t3_resp1_v", W'(req1_resp_v), W'(ord[k] == 1));
      if (ord[k] == 0) req0_yumi = 1'b1; else req1_yumi = 1'b1;
      #1;
      chk("t3_mem_yumi", W'(mem_yumi), W'(1));
      chk("t3_resp_data", (ord[k] == 0) ? req0_resp : req1_resp, W'(32'h300 + k));
      tick();
      mem_resp_v = 1'b0; req0_yumi = 1'b0; req1_yumi = 1'b0;
    end

    // 4: credit limit of 8 with no responses
    acc = 0;
    req0_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_cmd = W'(32'h400 + i);
      #1;
      if (req0_ready) acc++;
      tick();
    end
    chk("t4_accepted", W'(acc), W'(8));
    chk("t4_ready0_full", W'(req0_ready), W'(0));
    mem_resp_v = 1'b1; req0_yumi = 1'b1;
    #1 chk("t4_ready0_at_max_with_resp", W'(req0_ready), W'(1));
    tick();
    mem_resp_v = 1'b0; req0_yumi = 1'b0;
    #1 chk("t4_ready0_still_max", W'(req0_ready), W'(0));
    req0_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem_resp_v = 1'b1; req0_yumi = 1'b1;
      #1 chk("t4_drain_yumi", W'(mem_yumi), W'(1));
      tick();
    end
    mem_resp_v = 1'b0; req0_yumi = 1'b0;
    #1 chk("t4_empty_no_resp_v", W'(req0_resp_v), W'(0));
    tick();

    // 5: memory stalls for 5 cycles with a command held
    hs0 = mem_hs;
    req1_v = 1'b1; req1_cmd = W'(32'h500);
    tick();
    mem_ready = 1'b0; req1_cmd = W'(32'h501);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_stall_ready1", W'(req1_ready), W'(0));
      chk("t5_stall_data", mem_cmd, W'(32'h500));
      tick();
    end
    mem_ready = 1'b1;
    #1 chk("t5_resume_ready1", W'(req1_ready), W'(1));
    tick();
    req1_v = 1'b0;
    #1 chk("t5_next_data", mem_cmd, W'(32'h501));
    tick();
    chk("t5_handshakes", W'(mem_hs - hs0), W'(2));
    for (int k = 0; k < 2; k++) begin
      mem_resp_v = 1'b1; req1_yumi = 1'b1;
      #1 chk("t5_resp1_v", W'(req1_resp_v), W'(1));
      tick();
    end
    mem_resp_v = 1'b0; req1_yumi = 1'b0;
    tick();

    // 6: stray response sets sticky error, cleared only by reset
    mem_resp_v = 1'b1;
    #1;
    chk("t6_no_yumi", W'(mem_yumi), W'(0));
    chk("t6_no_resp_v", W'({req0_resp_v, req1_resp_v}), W'(0));
    tick();
    chk("t6_error_set", W'(error), W'(1));
    mem_resp_v = 1'b0;
    repeat (3) tick();
    chk("t6_error_sticky", W'(error), W'(1));
    reset_n = 1'b0;
    tick();
    chk("t6_error_reset", W'(error), W'(0));
    reset_n = 1'b1;
    tick();
    chk("t6_error_after_reset", W'(error), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
